// File: rtl/agc_gain_sequencer.sv
// AGC gain sequencer: windowed saturation detect, clamped gain stepping, lock and timeout.
// Optional AGC_HOLD_EN adds a hold input that freezes detect/settle progress.
`timescale 1ns/1ps
module agc_gain_sequencer #(
  parameter int unsigned GAIN_W       = 6,
  parameter int unsigned GAIN_INIT    = 32,
  parameter int unsigned GAIN_MIN     = 0,
  parameter int unsigned GAIN_MAX     = 63,
  parameter int unsigned STEP         = 2,
  parameter int unsigned DETECT_LEN   = 16,
  parameter int unsigned SETTLE_LEN   = 8,
  parameter int unsigned HI_THR       = 4,
  parameter int unsigned LO_THR       = 8,
  parameter int unsigned LOCK_WINDOWS = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  input  logic              sat_hi,
  input  logic              sat_lo,
  input  logic              done_in,
`ifdef AGC_HOLD_EN
  input  logic              hold,
`endif
  output logic [GAIN_W-1:0] gain,
  output logic              adjust,
  output logic              up_dn,
  output logic              detect_mode,
  output logic              busy,
  output logic              locked,
  output logic              timed_out,
  output logic              at_limit
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDetect = 3'd1;
  localparam logic [2:0] StAdjust = 3'd2;
  localparam logic [2:0] StSettle = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam int unsigned WIN_W = $clog2(DETECT_LEN);
  localparam int unsigned CNT_W = $clog2(DETECT_LEN + 1);
  localparam int unsigned TOT_W = CNT_W + 1;
  localparam int unsigned SET_W = $clog2(SETTLE_LEN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned STB_W = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned SW    = GAIN_W + 2;

  logic [2:0]        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              up_dn_q, up_dn_d, at_limit_q, at_limit_d;
  logic              locked_q, locked_d, timed_out_q, timed_out_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [STB_W-1:0]  stable_q, stable_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TOT_W-1:0]  hi_tot, lo_tot;
  logic signed [SW-1:0] g_ext, g_sum;
  logic              hold_act;

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    up_dn_d     = up_dn_q;
    at_limit_d  = at_limit_q;
    locked_d    = locked_q;
    timed_out_d = timed_out_q;
    win_d       = win_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    stable_d    = stable_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    // Window decision includes the current cycle's samples.
    hi_tot      = {1'b0, hi_q} + {{CNT_W{1'b0}}, sat_hi};
    lo_tot      = {1'b0, lo_q} + {{CNT_W{1'b0}}, sat_lo};
    // Two guard bits keep both overflow past GAIN_MAX and underflow below zero visible.
    g_ext       = $signed({2'b00, gain_q});
    g_sum       = up_dn_q ? g_ext + $signed(SW'(STEP)) : g_ext - $signed(SW'(STEP));
    hold_act    = 1'b0;
`ifdef AGC_HOLD_EN
    hold_act    = hold && (state_q == StDetect || state_q == StSettle);
`endif

    if (state_q == StIdle || state_q == StDone) begin
      if (start) begin
        state_d     = StDetect;
        gain_d      = GAIN_W'(GAIN_INIT);
        at_limit_d  = 1'b0;
        locked_d    = 1'b0;
        timed_out_d = 1'b0;
        win_d       = '0;
        hi_d        = '0;
        lo_d        = '0;
        stable_d    = '0;
        settle_d    = '0;
        tmo_d       = '0;
      end
    end else if (!hold_act) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        state_d     = StDone;
        timed_out_d = 1'b1;
      end else if (done_in) begin
        state_d  = StDone;
        locked_d = 1'b1;
      end else begin
        case (state_q)
          StDetect: begin
            win_d = win_q + 1'b1;
            if (sat_hi && hi_q != CNT_W'(DETECT_LEN)) hi_d = hi_q + 1'b1;
            if (sat_lo && lo_q != CNT_W'(DETECT_LEN)) lo_d = lo_q + 1'b1;
            if (win_q == WIN_W'(DETECT_LEN - 1)) begin
              win_d = '0;
              hi_d  = '0;
              lo_d  = '0;
              if (hi_tot >= TOT_W'(HI_THR)) begin
                state_d = StAdjust;
                up_dn_d = 1'b0;
              end else if (lo_tot >= TOT_W'(LO_THR)) begin
                state_d = StAdjust;
                up_dn_d = 1'b1;
              end else begin
                stable_d = stable_q + 1'b1;
                if (stable_d >= STB_W'(LOCK_WINDOWS)) begin
                  state_d  = StDone;
                  locked_d = 1'b1;
                end
              end
            end
          end
          StAdjust: begin
            if (g_sum > $signed(SW'(GAIN_MAX))) begin
              gain_d     = GAIN_W'(GAIN_MAX);
              at_limit_d = 1'b1;
            end else if (g_sum < $signed(SW'(GAIN_MIN))) begin
              gain_d     = GAIN_W'(GAIN_MIN);
              at_limit_d = 1'b1;
            end else begin
              gain_d     = g_sum[GAIN_W-1:0];
              at_limit_d = 1'b0;
            end
            stable_d = '0;
            settle_d = '0;
            state_d  = StSettle;
          end
          StSettle: begin
            if (settle_q == SET_W'(SETTLE_LEN - 1)) begin
              settle_d = '0;
              state_d  = StDetect;
            end else begin
              settle_d = settle_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= StIdle;
      gain_q      <= GAIN_W'(GAIN_INIT);
      up_dn_q     <= 1'b1;
      at_limit_q  <= 1'b0;
      locked_q    <= 1'b0;
      timed_out_q <= 1'b0;
      win_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      stable_q    <= '0;
      settle_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      up_dn_q     <= up_dn_d;
      at_limit_q  <= at_limit_d;
      locked_q    <= locked_d;
      timed_out_q <= timed_out_d;
      win_q       <= win_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      stable_q    <= stable_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
    end
  end

  assign gain        = gain_q;
  assign up_dn       = up_dn_q;
  assign at_limit    = at_limit_q;
  assign locked      = locked_q;
  assign timed_out   = timed_out_q;
  assign adjust      = (state_q == StAdjust);
  assign detect_mode = (state_q == StDetect);
  assign busy        = (state_q == StDetect) || (state_q == StAdjust) || (state_q == StSettle);

endmodule
